// File: rtl/sci_alu_pkg.sv
// Shared definitions for the sequential scientific ALU.
//   op_e          : 4-bit opcode encoding (codes above OP_LAST_LEGAL are illegal)
//   iter_kind_e   : which recurrence the iterative datapath runs
//   iter_count()  : number of iteration cycles an opcode needs for a given width
package sci_alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_REM  = 4'd4,
    OP_SQRT = 4'd5,
    OP_MIN  = 4'd6,
    OP_MAX  = 4'd7,
    OP_ABS  = 4'd8,
    OP_NEG  = 4'd9
  } op_e;

  localparam logic [OP_W-1:0] OP_LAST_LEGAL = 4'd9;

  typedef enum logic [1:0] {
    K_MUL,
    K_DIV,
    K_SQRT
  } iter_kind_e;

  // MUL/DIV/REM retire one bit per cycle, SQRT consumes two radicand bits per cycle.
  function automatic int iter_count(input logic [OP_W-1:0] op, input int width);
    case (op)
      OP_MUL, OP_DIV, OP_REM: return width;
      OP_SQRT:                return width / 2;
      default:                return 0;
    endcase
  endfunction

endpackage

// File: rtl/sci_alu_seq_if.sv
// Request/result bus of the sequential ALU.
//   in_valid/in_ready   : request handshake, carrying in_op, in_a, in_b, in_tag
//   out_valid/out_ready : result handshake, carrying out_result, out_excep, out_err, out_tag
// master = command source / result consumer, slave = the ALU.
interface sci_alu_seq_if
  import sci_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_excep;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_excep, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_excep, out_err, out_tag
  );
endinterface

// File: rtl/sci_alu_iter.sv
// Shared iterative datapath working on unsigned magnitudes.
//   start        : load operands for op (MUL, DIV/REM or SQRT) and arm the counter
//   a_mag, b_mag : operand magnitudes (SQRT uses a_mag only)
//   done         : the step taken at this clock edge is the last one
//   res_hi/lo    : register values after this step; valid with done
//                  MUL -> {res_hi,res_lo} full product; DIV/REM -> res_lo quotient,
//                  res_hi remainder; SQRT -> res_lo root
module sci_alu_iter
  import sci_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  iter_kind_e       kind_q;
  logic [CNT_W-1:0] cnt_q;
  // hi: product high half / partial remainder; lo: multiplier->product low /
  // dividend->quotient / root; x: multiplicand / divisor / unconsumed radicand
  logic [WIDTH-1:0] hi_q, lo_q, x_q;
  logic [WIDTH-1:0] hi_n, lo_n, x_n;
  logic [WIDTH:0]   sum, tr;
  logic [WIDTH+1:0] tr2;
  logic             ge;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    hi_n = hi_q;
    lo_n = lo_q;
    x_n  = x_q;
    ge   = 1'b0;
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, x_q} : '0);
    tr   = {hi_q, lo_q[WIDTH-1]};
    tr2  = {hi_q, x_q[WIDTH-1 -: 2]};
    case (kind_q)
      K_MUL: begin
        // shift-add: add multiplicand if the multiplier LSB is set, then shift right
        hi_n = sum[WIDTH:1];
        lo_n = {sum[0], lo_q[WIDTH-1:1]};
      end
      K_DIV: begin
        // restoring division; the difference fits WIDTH bits whenever it is kept
        ge   = (tr >= {1'b0, x_q});
        hi_n = ge ? (tr[WIDTH-1:0] - x_q) : tr[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], ge};
      end
      default: begin
        // digit-by-digit root: trial subtrahend is 4*root + 1
        ge   = (tr2 >= {lo_q, 2'b01});
        hi_n = ge ? (tr2[WIDTH-1:0] - {lo_q[WIDTH-3:0], 2'b01}) : tr2[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], ge};
        x_n  = {x_q[WIDTH-3:0], 2'b00};
      end
    endcase
  end

  assign done   = (cnt_q == CNT_W'(1));
  assign res_hi = hi_n;
  assign res_lo = lo_n;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q <= K_MUL;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      x_q    <= '0;
    end else if (start) begin
      cnt_q <= CNT_W'(iter_count(op, WIDTH));
      hi_q  <= '0;
      case (op)
        OP_MUL: begin
          kind_q <= K_MUL;
          lo_q   <= b_mag;
          x_q    <= a_mag;
        end
        OP_DIV, OP_REM: begin
          kind_q <= K_DIV;
          lo_q   <= a_mag;
          x_q    <= b_mag;
        end
        default: begin
          kind_q <= K_SQRT;
          lo_q   <= '0;
          x_q    <= a_mag;
        end
      endcase
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      x_q   <= x_n;
    end
  end

endmodule

// File: rtl/sci_alu_seq.sv
// Sequential signed fixed-point ALU with valid/ready handshakes and tags.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : sci_alu_seq_if slave (request in_*, result out_*)
// Single-cycle ops and early exits complete one cycle after acceptance; MUL,
// DIV, REM and SQRT run on sci_alu_iter and get their sign fixed up here.
module sci_alu_seq
  import sci_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  sci_alu_seq_if.slave bus
);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e          state_q;
  logic [OP_W-1:0] op_q;
  logic            sign_q;   // sign of the final result (MUL/DIV/REM)
  logic            ovf_q;    // DIV of MIN by -1

  logic             accept;
  logic             a_neg, b_neg, go_iter, quick_exc, quick_err;
  logic [WIDTH-1:0] a_mag, b_mag, sum_ab, dif_ab, quick_res;
  logic             it_done;
  logic [WIDTH-1:0] it_hi, it_lo, fix_res;
  logic             fix_exc;

  assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == S_DONE);
  assign accept        = bus.in_valid && bus.in_ready;

  // Decode of the incoming request: single-cycle results and early exits.
  always_comb begin
    a_neg     = bus.in_a[WIDTH-1];
    b_neg     = bus.in_b[WIDTH-1];
    a_mag     = a_neg ? -bus.in_a : bus.in_a;
    b_mag     = b_neg ? -bus.in_b : bus.in_b;
    sum_ab    = bus.in_a + bus.in_b;
    dif_ab    = bus.in_a - bus.in_b;
    go_iter   = 1'b0;
    quick_res = '0;
    quick_exc = 1'b0;
    quick_err = 1'b0;
    if (bus.in_op > OP_LAST_LEGAL) begin
      quick_err = 1'b1;
    end else begin
      case (bus.in_op)
        OP_ADD: begin
          quick_res = sum_ab;
          quick_exc = (a_neg == b_neg) && (sum_ab[WIDTH-1] != a_neg);
        end
        OP_SUB: begin
          quick_res = dif_ab;
          quick_exc = (a_neg != b_neg) && (dif_ab[WIDTH-1] != a_neg);
        end
        OP_MUL: go_iter = 1'b1;
        OP_DIV: begin
          if (bus.in_b == '0) quick_exc = 1'b1;
          else                go_iter   = 1'b1;
        end
        OP_REM: begin
          if (bus.in_b == '0) begin
            quick_res = bus.in_a;
            quick_exc = 1'b1;
          end else begin
            go_iter = 1'b1;
          end
        end
        OP_SQRT: begin
          if (a_neg) quick_exc = 1'b1;
          else       go_iter   = 1'b1;
        end
        OP_MIN: quick_res = ($signed(bus.in_a) < $signed(bus.in_b)) ? bus.in_a : bus.in_b;
        OP_MAX: quick_res = ($signed(bus.in_a) < $signed(bus.in_b)) ? bus.in_b : bus.in_a;
        OP_ABS: begin
          quick_res = a_mag;
          quick_exc = (bus.in_a == MIN_VAL);
        end
        default: begin  // OP_NEG
          quick_res = -bus.in_a;
          quick_exc = (bus.in_a == MIN_VAL);
        end
      endcase
    end
  end

  sci_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && go_iter),
    .op     (bus.in_op),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .done   (it_done),
    .res_hi (it_hi),
    .res_lo (it_lo)
  );

  // Sign fix-up of the magnitude results and MUL overflow detection: a negative
  // product may reach 2^(WIDTH-1) in magnitude, a positive one must stay below it.
  always_comb begin
    fix_res = it_lo;
    fix_exc = 1'b0;
    case (op_q)
      OP_MUL: begin
        fix_res = sign_q ? -it_lo : it_lo;
        fix_exc = sign_q ? !((it_hi == '0) && (it_lo <= MIN_VAL))
                         : !((it_hi == '0) && !it_lo[WIDTH-1]);
      end
      OP_DIV: begin
        fix_res = sign_q ? -it_lo : it_lo;
        fix_exc = ovf_q;
      end
      OP_REM:  fix_res = sign_q ? -it_hi : it_hi;
      default: fix_res = it_lo;
    endcase
  end

  // NOTE: result registers are reset along with the FSM so every output reads 0
  // after reset, not just out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      sign_q         <= 1'b0;
      ovf_q          <= 1'b0;
      bus.out_result <= '0;
      bus.out_excep  <= 1'b0;
      bus.out_err    <= 1'b0;
      bus.out_tag    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            // accept in DONE implies the held result transfers on this same edge
            op_q        <= bus.in_op;
            sign_q      <= (bus.in_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
            ovf_q       <= (bus.in_a == MIN_VAL) && (bus.in_b == '1);
            bus.out_tag <= bus.in_tag;
            if (go_iter) begin
              state_q <= S_BUSY;
            end else begin
              state_q        <= S_DONE;
              bus.out_result <= quick_res;
              bus.out_excep  <= quick_exc;
              bus.out_err    <= quick_err;
            end
          end else if ((state_q == S_DONE) && bus.out_ready) begin
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (it_done) begin
            state_q        <= S_DONE;
            bus.out_result <= fix_res;
            bus.out_excep  <= fix_exc;
            bus.out_err    <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sci_alu_seq.sv
module tb_sci_alu_seq;
  import sci_alu_pkg::*;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
    logic          exc;
    logic          err;
    int            lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    logic         err;
    int           lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  sci_alu_seq_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  sci_alu_seq #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [TW-1:0] tag, input logic [W-1:0] res,
                              input logic exc, input logic err, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag;
    v.res = res; v.exc = exc; v.err = err; v.lat = lat;
    return v;
  endfunction

  // Reference model: plain 64-bit signed arithmetic and range checks.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, r, lo, hi, mid;
    longint maxi = 64'sd2147483647;
    longint mini = -64'sd2147483648;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    e.exc = 1'b0;
    e.err = 1'b0;
    e.lat = 1;
    case (op)
      4'd0: begin r = sa + sb; e.exc = (r > maxi) || (r < mini); end
      4'd1: begin r = sa - sb; e.exc = (r > maxi) || (r < mini); end
      4'd2: begin r = sa * sb; e.exc = (r > maxi) || (r < mini); e.lat = W + 1; end
      4'd3: begin
        if (sb == 0) e.exc = 1'b1;
        else begin r = sa / sb; e.exc = (r > maxi); e.lat = W + 1; end
      end
      4'd4: begin
        if (sb == 0) begin r = sa; e.exc = 1'b1; end
        else begin r = sa % sb; e.lat = W + 1; end
      end
      4'd5: begin
        if (sa < 0) e.exc = 1'b1;
        else begin
          lo = 0; hi = 65536;
          while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= sa) lo = mid; else hi = mid;
          end
          r = lo;
          e.lat = W / 2 + 1;
        end
      end
      4'd6: r = (sa < sb) ? sa : sb;
      4'd7: r = (sa < sb) ? sb : sa;
      4'd8: begin r = (sa < 0) ? -sa : sa; e.exc = (r > maxi); end
      4'd9: begin r = -sa; e.exc = (r > maxi); end
      default: e.err = 1'b1;
    endcase
    e.res = r[W-1:0];
    return e;
  endfunction

  // Entered just after a falling edge; returns on the falling edge where out_valid is seen.
  task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag, input logic [W-1:0] e_res,
                       input logic e_exc, input logic e_err, input int e_lat);
    int n;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    #1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_op    = ~op;
    bus.in_a     = ~a;
    bus.in_b     = a ^ b;
    bus.in_tag   = ~tag;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (bus.out_valid !== 1'b1 && n < 200);
    check($sformatf("%s_lat", name), 64'(n), 64'(e_lat));
    check($sformatf("%s_res", name), bus.out_result, e_res);
    check($sformatf("%s_exc", name), bus.out_excep, e_exc);
    check($sformatf("%s_err", name), bus.out_err, e_err);
    check($sformatf("%s_tag", name), bus.out_tag, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] a, b;
    logic [3:0]   op;
    exp_t         e;
    int           cnt;

    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // opcode sweep a=16 b=2, expected values written out by hand
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] r;
      int l;
      case (i)
        0: r = 32'd18;  1: r = 32'd14;  2: r = 32'd32;  3: r = 32'd8;
        4: r = 32'd0;   5: r = 32'd4;   6: r = 32'd2;   7: r = 32'd16;
        8: r = 32'd16;  9: r = 32'hFFFF_FFF0;
        default: r = 32'd0;
      endcase
      l = (i >= 2 && i <= 4) ? 33 : (i == 5) ? 17 : 1;
      vecs.push_back(mk(4'(i), 32'd16, 32'd2, 4'(i), r, 1'b0, (i >= 10), l));
    end
    // signed edges and overflow
    vecs.push_back(mk(4'd3, 32'hFFFF_FFF9, 32'd2,        4'd1,  32'hFFFF_FFFD, 1'b0, 1'b0, 33));
    vecs.push_back(mk(4'd4, 32'hFFFF_FFF9, 32'd2,        4'd2,  32'hFFFF_FFFF, 1'b0, 1'b0, 33));
    vecs.push_back(mk(4'd3, 32'd5,         32'd0,        4'd3,  32'd0,         1'b1, 1'b0, 1));
    vecs.push_back(mk(4'd3, MINV,          32'hFFFF_FFFF, 4'd4, MINV,          1'b1, 1'b0, 33));
    vecs.push_back(mk(4'd5, 32'hFFFF_FFFC, 32'd0,        4'd5,  32'd0,         1'b1, 1'b0, 1));
    vecs.push_back(mk(4'd0, 32'h7FFF_FFFF, 32'd1,        4'd6,  MINV,          1'b1, 1'b0, 1));
    vecs.push_back(mk(4'd2, 32'h0001_0000, 32'h0001_0000, 4'd7, 32'd0,         1'b1, 1'b0, 33));
    vecs.push_back(mk(4'd2, 32'hFFFF_FFFD, 32'd5,        4'd8,  32'hFFFF_FFF1, 1'b0, 1'b0, 33));
    vecs.push_back(mk(4'd4, MINV,          32'hFFFF_FFFF, 4'd9, 32'd0,         1'b0, 1'b0, 33));
    vecs.push_back(mk(4'd4, 32'd5,         32'd0,        4'd10, 32'd5,         1'b1, 1'b0, 1));
    vecs.push_back(mk(4'd8, MINV,          32'd0,        4'd11, MINV,          1'b1, 1'b0, 1));
    vecs.push_back(mk(4'd9, MINV,          32'd0,        4'd12, MINV,          1'b1, 1'b0, 1));
    vecs.push_back(mk(4'd1, MINV,          32'd1,        4'd13, 32'h7FFF_FFFF, 1'b1, 1'b0, 1));
    vecs.push_back(mk(4'd5, 32'h7FFF_FFFF, 32'd0,        4'd14, 32'h0000_B504, 1'b0, 1'b0, 17));
    vecs.push_back(mk(4'd2, MINV,          32'hFFFF_FFFF, 4'd15, MINV,         1'b1, 1'b0, 33));
    vecs.push_back(mk(4'd2, MINV,          32'd1,        4'd0,  MINV,          1'b0, 1'b0, 33));

    // reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_outputs", {bus.out_result, bus.out_excep, bus.out_err, bus.out_tag}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid_ready", {bus.out_valid, bus.in_ready}, 2'b01);

    do_op("add_first", 4'd0, 32'd16, 32'd2, 4'd3, 32'd18, 1'b0, 1'b0, 1);

    // table-driven vectors, issued back to back with out_ready high
    for (int i = 0; i < vecs.size(); i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
            vecs[i].res, vecs[i].exc, vecs[i].err, vecs[i].lat);

    // backpressure: MUL result held for 10 cycles, then transfer + new accept together
    @(negedge clk);
    bus.out_ready = 1'b0;
    do_op("bp_mul", 4'd2, 32'd7, 32'hFFFF_FFF7, 4'd5, 32'hFFFF_FFC1, 1'b0, 1'b0, 33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i),
            {bus.out_valid, bus.in_ready, bus.out_tag, bus.out_excep, bus.out_result},
            {1'b1, 1'b0, 4'd5, 1'b0, 32'hFFFF_FFC1});
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    #1;
    check("bp_ready_same_cycle", bus.in_ready, 1'b1);
    do_op("bp_add", 4'd0, 32'd100, 32'd23, 4'd6, 32'd123, 1'b0, 1'b0, 1);

    // randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, 40)) - 32'd20;
        1: case ($urandom_range(0, 3)) 0: a = MINV; 1: a = 32'h7FFF_FFFF; 2: a = '0; default: a = '1; endcase
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 40)) - 32'd20;
        1: case ($urandom_range(0, 3)) 0: b = MINV; 1: b = 32'h7FFF_FFFF; 2: b = '0; default: b = '1; endcase
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      e = model(op, a, b);
      do_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, 4'(i), e.res, e.exc, e.err, e.lat);
    end

    // reset in the middle of a DIV: the DIV result must never appear
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 4'd3;
    bus.in_a     = 32'd1000;
    bus.in_b     = 32'd7;
    bus.in_tag   = 4'd9;
    #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid_ready", {bus.out_valid, bus.in_ready}, 2'b01);
    check("midrst_outputs", {bus.out_result, bus.out_excep, bus.out_err, bus.out_tag}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) cnt++;
    end
    check("midrst_no_result", 64'(cnt), 64'd0);
    do_op("after_rst_add", 4'd0, 32'd40, 32'd2, 4'd1, 32'd42, 1'b0, 1'b0, 1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sci_alu_seq.md
# sci_alu_seq

Parametrised, clocked successor to the combinational `scientific_alu`. It is a signed fixed-point arithmetic unit with valid/ready handshakes on input and output, a transaction tag, and multi-cycle iterative multiply, divide, remainder and square-root. It sits between a command source and a result consumer and carries the existing `excep`/`err` flag semantics forward per result.

## Interface
- `WIDTH`, 32: operand/result width, two's complement; must be even and ≥4.
- `TAG_W`, 4: width of the transaction tag carried from request to result.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request this cycle.
- `in_op` in 4: opcode.
- `in_a`, `in_b` in WIDTH: operands.
- `in_tag` in TAG_W: request tag.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: consumer accepts result.
- `out_result` out WIDTH: result.
- `out_excep` out 1: arithmetic exception for this result.
- `out_err` out 1: illegal opcode for this result.
- `out_tag` out TAG_W: tag of the request that produced the result.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 DIV (signed, truncate toward zero), 4 REM (sign follows `a`), 5 SQRT (floor isqrt of `a`), 6 MIN, 7 MAX, 8 ABS(`a`), 9 NEG(`a`). Opcodes 10–15 are illegal.
- Handshake: a request transfers when `in_valid && in_ready`. A result transfers when `out_valid && out_ready`. Operands, op and tag are registered at acceptance and may change afterwards.
- FSM states:
  - IDLE: `in_ready=1`.
  - BUSY: iterating; `in_ready=0`.
  - DONE: `out_valid=1`; `in_ready=out_ready`, so back-to-back transfer is allowed in the same cycle.
- FSM transitions:
  - IDLE → DONE on accept of a single-cycle op or early-exit case.
  - IDLE → BUSY on accept of MUL, DIV, REM or SQRT.
  - BUSY → DONE when the iteration counter expires.
  - DONE → IDLE on result transfer with no new accept.
  - DONE → DONE or BUSY on simultaneous transfer and accept.
- Exceptions (`out_excep=1`, `out_err=0`):
  - ADD/SUB signed overflow: result wraps.
  - MUL: full 2·WIDTH product not representable in WIDTH bits; result is the low bits.
  - DIV/REM by zero: early exit; DIV result 0, REM result `a`.
  - DIV of MIN by −1: result MIN. REM of MIN by −1: result 0, no exception.
  - ABS/NEG of MIN: result MIN.
  - SQRT of negative `a`: early exit, result 0.
- Illegal op: `out_err=1`, `out_excep=0`, result 0, early exit.
- `out_result`, `out_excep`, `out_err` and `out_tag` are stable while `out_valid=1 && out_ready=0`.

## Timing
- Acceptance edge is cycle 0.
- Single-cycle ops and early exits: `out_valid` rises at cycle 1.
- MUL, DIV, REM: one bit per cycle; `out_valid` at cycle WIDTH+1.
- SQRT: two radicand bits per cycle; `out_valid` at cycle WIDTH/2+1.
- Throughput: one result per latency period when `out_ready` is held high. No idle bubble between results.
- Reset: `rst_n` low clears the FSM to IDLE immediately. `out_valid=0`, `in_ready=1` after deassertion; all other outputs 0.
- Reset mid-operation: any in-flight operation and any unaccepted result are discarded.
- `in_ready` is combinationally dependent on `out_ready` in DONE only.

## Structure
- Shared package `sci_alu_pkg` holds:
  - the 4-bit opcode enum and the `OP_LAST_LEGAL=9` constant;
  - a function returning the iteration count per op, given WIDTH.
- Sub-module `sci_alu_iter` holds the shared shift/add-subtract datapath for MUL (shift-add on magnitudes), DIV/REM (restoring on magnitudes) and SQRT (digit-by-digit). It has start/done signals and a counter.
- The top level owns the FSM, handshakes, sign fix-up, single-cycle ops and flag generation.

## Test plan
All cases use WIDTH=32.
- Reset and ADD: after reset, check `out_valid=0` and `in_ready=1`. Then ADD a=16, b=2, tag=3 → result 18 at cycle 1, `excep=0`, `err=0`, `tag=3`.
- Full opcode sweep: a=16, b=2, opcodes 0–15, `out_ready` always 1 → results 18, 14, 32, 8, 0, 4, 2, 16, 16, −16. Opcodes 10–15 give `err=1`, result 0. Check tags in order, with MUL/DIV/REM/SQRT latencies 33/33/33/17.
- Signed edges:
  - DIV −7/2 → −3; REM −7/2 → −1.
  - DIV 5/0 → `excep=1`, result 0 at cycle 1.
  - DIV 0x80000000/−1 → `excep=1`, result 0x80000000.
  - SQRT −4 → `excep=1`, result 0.
- Overflow: ADD 0x7FFFFFFF+1 → 0x80000000 with `excep=1`. MUL 0x10000×0x10000 → 0 with `excep=1`. MUL −3×5 → −15 with `excep=0`.
- Backpressure: hold `out_ready=0` for 10 cycles after a MUL result → result and tag stable, `in_ready=0`. Then assert `out_ready` together with a new `in_valid` → same-cycle transfer of both.
- Reset mid-op: drop `rst_n` at cycle 10 of a DIV → `out_valid` is never asserted for that DIV. After release, the next ADD completes normally.
